// File: rtl/fetch_control.sv
// Multi-cycle fetch/decode/control sequencer: fetches one word over a req/ack
// handshake, decodes it into datapath strobes, then advances the PC.
module fetch_control #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        MemRead,
  output logic [2:0]  ALUControl,
  output logic [25:0] Inst,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_NEXT, S_HALT
  } state_e;

  typedef enum logic [1:0] {K_ALU, K_LW, K_SW, K_NOP} kind_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_q, retired_d;

  kind_e       dec_kind;
  logic        dec_regdst, dec_alusrc, dec_memtoreg;
  logic [2:0]  dec_aluctl;
  logic [5:0]  op, funct;

  assign op        = ir_q[31:26];
  assign funct     = ir_q[5:0];
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign retired   = retired_q;
  assign Inst      = ir_q[25:0];

  // Unsupported opcodes and R-type functs fall through as K_NOP with all fields 0
  always_comb begin
    dec_kind     = K_NOP;
    dec_regdst   = 1'b0;
    dec_alusrc   = 1'b0;
    dec_memtoreg = 1'b0;
    dec_aluctl   = 3'b000;
    case (op)
      6'b000000: begin
        dec_kind   = K_ALU;
        dec_regdst = 1'b1;
        case (funct)
          6'b100000: dec_aluctl = 3'b010;
          6'b100010: dec_aluctl = 3'b110;
          6'b100100: dec_aluctl = 3'b000;
          6'b100101: dec_aluctl = 3'b001;
          6'b101010: dec_aluctl = 3'b111;
          default: begin
            dec_kind   = K_NOP;
            dec_regdst = 1'b0;
          end
        endcase
      end
      6'b001000: begin
        dec_kind   = K_ALU;
        dec_alusrc = 1'b1;
        dec_aluctl = 3'b010;
      end
      6'b100011: begin
        dec_kind     = K_LW;
        dec_alusrc   = 1'b1;
        dec_memtoreg = 1'b1;
        dec_aluctl   = 3'b010;
      end
      6'b101011: begin
        dec_kind   = K_SW;
        dec_alusrc = 1'b1;
        dec_aluctl = 3'b010;
      end
      default: dec_kind = K_NOP;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    retired_d  = retired_q;
    imem_req   = 1'b0;
    halted     = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    ALUSrc     = 1'b0;
    MemWrite   = 1'b0;
    MemToReg   = 1'b0;
    MemRead    = 1'b0;
    ALUControl = 3'b000;

    // Decoded fields stay visible for the whole active part of an instruction
    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      RegDst     = dec_regdst;
      ALUSrc     = dec_alusrc;
      MemToReg   = dec_memtoreg;
      ALUControl = dec_aluctl;
    end

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_q == HALT_WORD) begin
          state_d = S_HALT;
        end else begin
          case (dec_kind)
            K_ALU:       state_d = S_EXEC;
            K_LW, K_SW:  state_d = S_MEM;
            default:     state_d = S_NEXT;
          endcase
        end
      end
      S_EXEC: begin
        RegWrite = 1'b1;
        state_d  = S_NEXT;
      end
      S_MEM: begin
        if (dec_kind == K_LW) begin
          MemRead = 1'b1;
          state_d = S_WB;
        end else begin
          MemWrite = 1'b1;
          state_d  = S_NEXT;
        end
      end
      S_WB: begin
        MemRead  = 1'b1;
        MemToReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_NEXT;
      end
      S_NEXT: begin
        pc_d      = pc_q + 32'd4;
        retired_d = retired_q + 32'd1;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0;
      retired_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control: add, delayed-ack lw, sw, NOP, halt,
// mid-instruction reset and PC wrap-around on a second instance.
module tb_fetch_control;

  logic        clk = 1'b0;
  logic        rst_n, imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req, RegDst, RegWrite, ALUSrc, MemWrite, MemToReg, MemRead, halted;
  logic [2:0]  ALUControl;
  logic [25:0] Inst;
  logic [31:0] imem_addr, pc, retired;

  logic        rst_n_b, imem_ack_b;
  logic [31:0] imem_rdata_b;
  logic        imem_req_b, RegDst_b, RegWrite_b, ALUSrc_b, MemWrite_b, MemToReg_b, MemRead_b, halted_b;
  logic [2:0]  ALUControl_b;
  logic [25:0] Inst_b;
  logic [31:0] imem_addr_b, pc_b, retired_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_control dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrc(ALUSrc), .MemWrite(MemWrite), .MemToReg(MemToReg), .MemRead(MemRead),
    .ALUControl(ALUControl), .Inst(Inst), .pc(pc), .retired(retired), .halted(halted)
  );

  fetch_control #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n_b), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
    .imem_ack(imem_ack_b), .imem_rdata(imem_rdata_b), .RegDst(RegDst_b), .RegWrite(RegWrite_b),
    .ALUSrc(ALUSrc_b), .MemWrite(MemWrite_b), .MemToReg(MemToReg_b), .MemRead(MemRead_b),
    .ALUControl(ALUControl_b), .Inst(Inst_b), .pc(pc_b), .retired(retired_b), .halted(halted_b)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // RegWrite and MemWrite must never be high together
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_cmp++;
      assert (!(RegWrite === 1'b1 && MemWrite === 1'b1)) else begin
        n_err++;
        $error("[TB] FAIL rw_mw_excl: observed RegWrite=%b MemWrite=%b expected not both 1",
               RegWrite, MemWrite);
      end
    end
  end

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    rst_n_b = 1'b0; imem_ack_b = 1'b0; imem_rdata_b = 32'h0;
    step(); step();
    check_output("rst_req", imem_req, 1);
    check_output("rst_pc", pc, 32'h0);
    check_output("rst_retired", retired, 0);
    check_output("rst_halted", halted, 0);

    // add $3,$1,$2 with zero-wait ack
    imem_ack = 1'b1; imem_rdata = 32'h0022_1820; rst_n = 1'b1;
    #1;
    check_output("add_fetch_req", imem_req, 1);
    check_output("add_fetch_addr", imem_addr, 32'h0);
    step();
    check_output("add_dec_regwrite", RegWrite, 0);
    check_output("add_dec_regdst", RegDst, 1);
    step();
    check_output("add_exec_regwrite", RegWrite, 1);
    check_output("add_exec_regdst", RegDst, 1);
    check_output("add_exec_aluctl", ALUControl, 3'b010);
    check_output("add_exec_inst", Inst, 26'h022_1820);
    check_output("add_exec_alusrc", ALUSrc, 0);
    step();
    check_output("add_next_regwrite", RegWrite, 0);
    check_output("add_next_pc", pc, 32'h0);
    step();
    check_output("add_pc", pc, 32'h4);
    check_output("add_retired", retired, 1);

    // lw with ack held off for three cycles
    imem_ack = 1'b0; imem_rdata = 32'h8C43_0004;
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("lw_wait_req", imem_req, 1);
      check_output("lw_wait_addr", imem_addr, 32'h4);
    end
    imem_ack = 1'b1;
    step();
    check_output("lw_dec_memtoreg", MemToReg, 1);
    check_output("lw_dec_memread", MemRead, 0);
    check_output("lw_dec_req", imem_req, 0);
    // ack outside FETCH must not disturb ir; the sw word is fetched after NEXT
    imem_rdata = 32'hAC43_0008;
    step();
    check_output("lw_mem_memread", MemRead, 1);
    check_output("lw_mem_alusrc", ALUSrc, 1);
    check_output("lw_mem_regwrite", RegWrite, 0);
    check_output("lw_mem_inst", Inst, 26'h043_0004);
    step();
    check_output("lw_wb_regwrite", RegWrite, 1);
    check_output("lw_wb_memtoreg", MemToReg, 1);
    check_output("lw_wb_memread", MemRead, 1);
    step();
    check_output("lw_next_regwrite", RegWrite, 0);
    check_output("lw_next_memread", MemRead, 0);
    step();
    check_output("lw_pc", pc, 32'h8);
    check_output("lw_retired", retired, 2);

    // sw: one MemWrite cycle, no RegWrite
    step();
    check_output("sw_dec_memwrite", MemWrite, 0);
    check_output("sw_dec_regwrite", RegWrite, 0);
    step();
    check_output("sw_mem_memwrite", MemWrite, 1);
    check_output("sw_mem_regwrite", RegWrite, 0);
    check_output("sw_mem_alusrc", ALUSrc, 1);
    check_output("sw_mem_aluctl", ALUControl, 3'b010);
    step();
    check_output("sw_next_memwrite", MemWrite, 0);
    check_output("sw_next_regwrite", RegWrite, 0);
    step();
    check_output("sw_pc", pc, 32'hC);
    check_output("sw_retired", retired, 3);

    // Unsupported word then halt, from a fresh reset
    rst_n = 1'b0;
    step();
    check_output("rst2_pc", pc, 32'h0);
    check_output("rst2_retired", retired, 0);
    rst_n = 1'b1; imem_rdata = 32'h0C00_0000;
    step();
    check_output("nop_dec_regdst", RegDst, 0);
    check_output("nop_dec_alusrc", ALUSrc, 0);
    check_output("nop_dec_aluctl", ALUControl, 0);
    check_output("nop_dec_regwrite", RegWrite, 0);
    step();
    check_output("nop_next_regwrite", RegWrite, 0);
    check_output("nop_next_memwrite", MemWrite, 0);
    check_output("nop_next_memread", MemRead, 0);
    imem_rdata = 32'hFFFF_FFFF;
    step();
    check_output("nop_pc", pc, 32'h4);
    check_output("nop_retired", retired, 1);
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      check_output("halt_halted", halted, 1);
      check_output("halt_req", imem_req, 0);
      check_output("halt_pc", pc, 32'h4);
      check_output("halt_retired", retired, 1);
      step();
    end

    // Reset landing in the WB cycle of a lw
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; imem_rdata = 32'h8C43_0004;
    step();
    step();
    step();
    check_output("rstwb_wb_regwrite", RegWrite, 1);
    rst_n = 1'b0; imem_ack = 1'b0;
    step();
    check_output("rstwb_regwrite", RegWrite, 0);
    check_output("rstwb_memread", MemRead, 0);
    check_output("rstwb_pc", pc, 32'h0);
    check_output("rstwb_retired", retired, 0);
    check_output("rstwb_halted", halted, 0);
    rst_n = 1'b1;
    step();
    check_output("rstwb_req", imem_req, 1);
    check_output("rstwb_addr", imem_addr, 32'h0);

    // PC wrap from 0xFFFF_FFFC on the second instance
    check_output("wrap_rst_addr", imem_addr_b, 32'hFFFF_FFFC);
    imem_ack_b = 1'b1; imem_rdata_b = 32'h0022_1820; rst_n_b = 1'b1;
    step();
    step();
    check_output("wrap_exec_regwrite", RegWrite_b, 1);
    step();
    step();
    check_output("wrap_addr", imem_addr_b, 32'h0);
    check_output("wrap_retired", retired_b, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
